// File: rtl/h6_mul_sequencer.sv
// Control sequencer for the H6 shift-add multiplier: load, 16 x (P2,P3,P4) iterations,
// then a two-cycle write-back of the 32-bit product over the S bus. All outputs are registered.
module h6_mul_sequencer (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] src_a,
   input  logic [2:0] dst_hi,
   input  logic [2:0] dst_lo,
   output logic [7:0] ra_oh,
   output logic [7:0] sr_oh,
   output logic       B0B,
   output logic       MUL1,
   output logic       MUL2_1,
   output logic       MUL2_2,
   output logic       Rst_H6,
   output logic       inQLK,
   output logic       inTWO,
   output logic       inTHREE,
   output logic       inFOUR,
   output logic       ALS_H6_a,
   output logic       ALS_H6_q,
   output logic       MUL3,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_P2,
      S_P3,
      S_P4,
      S_WBH,
      S_WBL,
      S_DONE,
      S_ABORT
   } state_t;

   // R5 is backed by the PSW and must never be written from the S bus.
   localparam logic [2:0] PSW_REG = 3'd5;

   state_t     r_state;
   state_t     w_next;
   logic [4:0] r_cnt;
   logic [4:0] w_cntInc;
   logic [2:0] r_dstHi;
   logic [2:0] r_dstLo;

   logic [7:0] w_ra;
   logic [7:0] w_sr;
   logic       w_b0b;
   logic       w_mul1;
   logic       w_mul21;
   logic       w_mul22;
   logic       w_rstH6;
   logic       w_qlk;
   logic       w_two;
   logic       w_three;
   logic       w_four;
   logic       w_alsA;
   logic       w_alsQ;
   logic       w_mul3;
   logic       w_busy;
   logic       w_done;
   logic       w_err;

   assign w_cntInc = r_cnt + 5'd1;

   always_comb begin
      w_next = r_state;
      if (r_state == S_IDLE) begin
         if (start && !abort) begin
            w_next = S_LOAD;
         end
      end else if (abort) begin
         w_next = S_ABORT;
      end else begin
         case (r_state)
            S_LOAD:  w_next = S_P2;
            S_P2:    w_next = S_P3;
            S_P3:    w_next = S_P4;
            S_P4:    w_next = (w_cntInc == 5'd16) ? S_WBH : S_P2;
            S_WBH:   w_next = S_WBL;
            S_WBL:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_ABORT: w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so they line up with the state register.
   // LOAD is only entered from IDLE, so src_a is taken straight from the port on that edge.
   always_comb begin
      w_ra    = '0;
      w_sr    = '0;
      w_b0b   = 1'b0;
      w_mul1  = 1'b0;
      w_mul21 = 1'b0;
      w_mul22 = 1'b0;
      w_rstH6 = 1'b0;
      w_qlk   = 1'b0;
      w_two   = 1'b0;
      w_three = 1'b0;
      w_four  = 1'b0;
      w_alsA  = 1'b0;
      w_alsQ  = 1'b0;
      w_mul3  = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      w_err   = 1'b0;
      case (w_next)
         S_LOAD: begin
            w_ra    = 8'd1 << src_a;
            w_b0b   = 1'b1;
            w_mul1  = 1'b1;
            w_mul21 = 1'b1;
            w_mul22 = 1'b1;
            w_rstH6 = 1'b1;
            w_qlk   = 1'b1;
            w_busy  = 1'b1;
         end
         S_P2: begin
            w_two  = 1'b1;
            w_busy = 1'b1;
         end
         S_P3: begin
            w_three = 1'b1;
            w_busy  = 1'b1;
         end
         S_P4: begin
            w_four = 1'b1;
            w_busy = 1'b1;
         end
         S_WBH: begin
            w_alsA = 1'b1;
            w_mul3 = 1'b1;
            w_busy = 1'b1;
            if (r_dstHi != PSW_REG) begin
               w_sr = 8'd1 << r_dstHi;
            end
         end
         S_WBL: begin
            w_alsQ = 1'b1;
            w_mul3 = 1'b1;
            w_busy = 1'b1;
            if (r_dstLo != PSW_REG) begin
               w_sr = 8'd1 << r_dstLo;
            end
         end
         S_DONE: begin
            w_done = 1'b1;
            w_err  = (r_dstHi == PSW_REG) || (r_dstLo == PSW_REG);
         end
         S_ABORT: begin
            w_rstH6 = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_dstHi <= '0;
         r_dstLo <= '0;
      end else begin
         r_state <= w_next;
         if (w_next == S_LOAD) begin
            r_cnt   <= '0;
            r_dstHi <= dst_hi;
            r_dstLo <= dst_lo;
         end else if (r_state == S_P4 && !abort) begin
            r_cnt <= w_cntInc;
         end
      end
   end

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         ra_oh    <= '0;
         sr_oh    <= '0;
         B0B      <= 1'b0;
         MUL1     <= 1'b0;
         MUL2_1   <= 1'b0;
         MUL2_2   <= 1'b0;
         Rst_H6   <= 1'b0;
         inQLK    <= 1'b0;
         inTWO    <= 1'b0;
         inTHREE  <= 1'b0;
         inFOUR   <= 1'b0;
         ALS_H6_a <= 1'b0;
         ALS_H6_q <= 1'b0;
         MUL3     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         ra_oh    <= w_ra;
         sr_oh    <= w_sr;
         B0B      <= w_b0b;
         MUL1     <= w_mul1;
         MUL2_1   <= w_mul21;
         MUL2_2   <= w_mul22;
         Rst_H6   <= w_rstH6;
         inQLK    <= w_qlk;
         inTWO    <= w_two;
         inTHREE  <= w_three;
         inFOUR   <= w_four;
         ALS_H6_a <= w_alsA;
         ALS_H6_q <= w_alsQ;
         MUL3     <= w_mul3;
         busy     <= w_busy;
         done     <= w_done;
         err      <= w_err;
      end
   end

endmodule

// File: tb/tb_h6_mul_sequencer.sv
// Bench for h6_mul_sequencer: a small register-file/H6 model follows the control outputs
// so that products, write-back destinations, timing and corner cases can be checked.
module tb_h6_mul_sequencer;

   logic       CLK;
   logic       CLR;
   logic       start;
   logic       abort;
   logic [2:0] src_a;
   logic [2:0] dst_hi;
   logic [2:0] dst_lo;
   logic [7:0] ra_oh;
   logic [7:0] sr_oh;
   logic       B0B, MUL1, MUL2_1, MUL2_2, Rst_H6, inQLK;
   logic       inTWO, inTHREE, inFOUR, ALS_H6_a, ALS_H6_q, MUL3;
   logic       busy, done, err;

   h6_mul_sequencer dut (
      .CLK      (CLK),
      .CLR      (CLR),
      .start    (start),
      .abort    (abort),
      .src_a    (src_a),
      .dst_hi   (dst_hi),
      .dst_lo   (dst_lo),
      .ra_oh    (ra_oh),
      .sr_oh    (sr_oh),
      .B0B      (B0B),
      .MUL1     (MUL1),
      .MUL2_1   (MUL2_1),
      .MUL2_2   (MUL2_2),
      .Rst_H6   (Rst_H6),
      .inQLK    (inQLK),
      .inTWO    (inTWO),
      .inTHREE  (inTHREE),
      .inFOUR   (inFOUR),
      .ALS_H6_a (ALS_H6_a),
      .ALS_H6_q (ALS_H6_q),
      .MUL3     (MUL3),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [30:0] allOut;
   assign allOut = {ra_oh, sr_oh, B0B, MUL1, MUL2_1, MUL2_2, Rst_H6, inQLK,
                    inTWO, inTHREE, inFOUR, ALS_H6_a, ALS_H6_q, MUL3, busy, done, err};

   typedef struct {
      logic [15:0] b0;
      logic [15:0] a;
      logic [2:0]  src;
      logic [2:0]  dhi;
      logic [2:0]  dlo;
      logic [15:0] expHi;
      logic [15:0] expLo;
      logic        expErr;
   } vec_t;

   vec_t        vecs[6];
   int          checks = 0;
   int          failures = 0;
   logic [15:0] rf[8];
   logic [15:0] b0reg;
   logic [15:0] mA, mQ, mM;
   logic        mC;
   int          nTwo, nThree, nFour, nDone, nAlsQ, viol;
   logic        sr5Seen;

   function automatic int oh2idx(input logic [7:0] oh);
      int r = 0;
      for (int i = 0; i < 8; i++) if (oh[i]) r = i;
      return r;
   endfunction

   // Environment model: register file, B0 and the H6 unit reacting to the strobes mid-cycle.
   always @(negedge CLK) begin
      if (Rst_H6 && inQLK && MUL1 && B0B) begin
         mM = rf[oh2idx(ra_oh)];
         mA = 16'h0;
         mQ = b0reg;
         mC = 1'b0;
      end else if (Rst_H6) begin
         mA = 16'h0;
         mQ = 16'h0;
         mC = 1'b0;
      end
      if (inTWO) {mC, mA} = mQ[0] ? ({1'b0, mA} + {1'b0, mM}) : {1'b0, mA};
      if (inFOUR) begin
         {mA, mQ} = {mC, mA, mQ[15:1]};
         mC = 1'b0;
      end
      if (sr_oh != 8'h0 && MUL3 && ALS_H6_a) rf[oh2idx(sr_oh)] = mA;
      if (sr_oh != 8'h0 && MUL3 && ALS_H6_q) rf[oh2idx(sr_oh)] = mQ;
      if (inTWO) nTwo++;
      if (inTHREE) nThree++;
      if (inFOUR) nFour++;
      if (done) nDone++;
      if (ALS_H6_q) nAlsQ++;
      if (sr_oh[5]) sr5Seen = 1'b1;
      if ($countones(ra_oh) > 1 || $countones(sr_oh) > 1 ||
          (sr_oh != 8'h0 && (ra_oh != 8'h0 || B0B)) ||
          (int'(inTWO) + int'(inTHREE) + int'(inFOUR)) > 1 || (busy && done))
         viol++;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic presetRegs(input vec_t v);
      for (int i = 0; i < 8; i++) rf[i] = 16'hA000 + 16'(i);
      rf[v.src] = v.a;
      b0reg     = v.b0;
      nTwo = 0;
      nThree = 0;
      nFour = 0;
      sr5Seen = 1'b0;
   endtask

   // Drives start for one edge; returns on the negedge where LOAD outputs are visible.
   task automatic applyStimulus(input vec_t v);
      logic [30:0] expLoad;
      presetRegs(v);
      @(negedge CLK);
      src_a  = v.src;
      dst_hi = v.dhi;
      dst_lo = v.dlo;
      start  = 1'b1;
      @(negedge CLK);
      start  = 1'b0;
      src_a  = 3'd0;
      dst_hi = 3'd0;
      dst_lo = 3'd0;
      expLoad = '0;
      expLoad[30:23] = 8'd1 << v.src;
      expLoad[14:9]  = 6'b111111;
      expLoad[2]     = 1'b1;
      checkOutput("load_outputs", 32'(allOut), 32'(expLoad));
   endtask

   task automatic runMul(input vec_t v, input string tag);
      int lat;
      applyStimulus(v);
      lat = 0;
      while (!done && lat < 200) begin
         @(negedge CLK);
         lat++;
      end
      checkOutput({tag, "_latency"}, 32'(lat), 32'd51);
      checkOutput({tag, "_err"}, 32'(err), 32'(v.expErr));
      @(negedge CLK);
      #1;
      checkOutput({tag, "_rf_hi"}, 32'(rf[v.dhi]), 32'(v.expHi));
      checkOutput({tag, "_rf_lo"}, 32'(rf[v.dlo]), 32'(v.expLo));
      checkOutput({tag, "_n_two"}, 32'(nTwo), 32'd16);
      checkOutput({tag, "_n_three"}, 32'(nThree), 32'd16);
      checkOutput({tag, "_n_four"}, 32'(nFour), 32'd16);
      checkOutput({tag, "_sr5"}, 32'(sr5Seen), 32'd0);
   endtask

   initial begin
      int n, k, doneBefore, alsQBefore;
      logic [30:0] expAbort;

      vecs[0] = '{16'h0005, 16'h0003, 3'd1, 3'd2, 3'd3, 16'h0000, 16'h000F, 1'b0};
      vecs[1] = '{16'hFFFF, 16'hFFFF, 3'd0, 3'd4, 3'd6, 16'hFFFE, 16'h0001, 1'b0};
      vecs[2] = '{16'h1234, 16'h0010, 3'd7, 3'd5, 3'd1, 16'hA005, 16'h2340, 1'b1};
      vecs[3] = '{16'h0100, 16'h0300, 3'd2, 3'd7, 3'd7, 16'h0000, 16'h0000, 1'b0};
      vecs[4] = '{16'h00FF, 16'h0101, 3'd3, 3'd0, 3'd2, 16'h0000, 16'hFFFF, 1'b0};
      vecs[5] = '{16'h0002, 16'h8000, 3'd4, 3'd6, 3'd5, 16'h0001, 16'hA005, 1'b1};

      CLR = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      src_a = 3'd0;
      dst_hi = 3'd0;
      dst_lo = 3'd0;
      nDone = 0;
      nAlsQ = 0;
      viol = 0;
      presetRegs(vecs[0]);
      #12;
      checkOutput("reset_outputs", 32'(allOut), 32'd0);
      @(negedge CLK);
      CLR = 1'b1;
      @(negedge CLK);
      checkOutput("idle_outputs", 32'(allOut), 32'd0);

      for (int i = 0; i < 6; i++) runMul(vecs[i], $sformatf("vec%0d", i));

      // Abort raised while the 10th P3 is showing; expect one Rst_H6-only cycle then IDLE.
      doneBefore = nDone;
      applyStimulus(vecs[0]);
      k = 0;
      n = 0;
      while (k < 10 && n < 100) begin
         @(negedge CLK);
         n++;
         if (inTHREE) k++;
      end
      checkOutput("abort_reach_p3", 32'(k), 32'd10);
      abort = 1'b1;
      @(negedge CLK);
      abort = 1'b0;
      expAbort = '0;
      expAbort[10] = 1'b1;
      checkOutput("abort_cycle", 32'(allOut), 32'(expAbort));
      @(negedge CLK);
      checkOutput("abort_idle", 32'(allOut), 32'd0);
      repeat (60) @(negedge CLK);
      #1;
      checkOutput("abort_no_done", 32'(nDone - doneBefore), 32'd0);
      checkOutput("abort_r2", 32'(rf[2]), 32'hA002);
      checkOutput("abort_r3", 32'(rf[3]), 32'hA003);
      runMul(vecs[0], "after_abort");

      // Asynchronous clear during WBH must kill the write-back.
      applyStimulus(vecs[1]);
      n = 0;
      while (!ALS_H6_a && n < 100) begin
         @(negedge CLK);
         n++;
      end
      checkOutput("clr_reach_wbh", 32'(ALS_H6_a), 32'd1);
      #1;
      doneBefore = nDone;
      alsQBefore = nAlsQ;
      CLR = 1'b0;
      #1;
      checkOutput("clr_async_outputs", 32'(allOut), 32'd0);
      @(negedge CLK);
      CLR = 1'b1;
      repeat (10) @(negedge CLK);
      #1;
      checkOutput("clr_no_wbl", 32'(nAlsQ - alsQBefore), 32'd0);
      checkOutput("clr_no_done", 32'(nDone - doneBefore), 32'd0);
      checkOutput("clr_idle", 32'(allOut), 32'd0);

      // start pulses while busy (mid-loop and during DONE) must not queue a second run.
      doneBefore = nDone;
      applyStimulus(vecs[4]);
      n = 0;
      while (!done && n < 200) begin
         @(negedge CLK);
         n++;
         if (n == 20) start = 1'b1;
         if (n == 21) start = 1'b0;
      end
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (80) @(negedge CLK);
      #1;
      checkOutput("busy_start_one_done", 32'(nDone - doneBefore), 32'd1);
      checkOutput("busy_start_idle", 32'(allOut), 32'd0);

      checkOutput("invariants", 32'(viol), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
